// File: rtl/if_debug_ctrl.sv
// if_debug_ctrl: bring-up sequencer for the instruction-fetch stage.
// Assembles instructions from UART bytes into instruction memory, then runs
// the core continuously or one cycle per 'N', and reports the PC over UART.
module if_debug_ctrl #(
    parameter int                 NB_DATA     = 32,
    parameter int                 N_BITS_DATA = 8,
    parameter logic [NB_DATA-1:0] HALT_INSTR  = 32'hFC000000,
    parameter int                 ADDRWIDTH   = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   locked_i,
    input  logic [N_BITS_DATA-1:0] rx_data_i,
    input  logic                   rx_done_i,
    input  logic                   tx_done_i,
    input  logic                   halt_i,
    input  logic [ADDRWIDTH-1:0]   pc_i,
    output logic                   en_write_o,
    output logic [ADDRWIDTH-1:0]   wr_addr_o,
    output logic [NB_DATA-1:0]     instruction_o,
    output logic                   debug_unit_o,
    output logic                   en_read_o,
    output logic                   enable_o,
    output logic                   tx_start_o,
    output logic [N_BITS_DATA-1:0] tx_data_o,
    output logic                   done_o
);

    localparam int NB_BYTES = NB_DATA / N_BITS_DATA;
    localparam int CNT_W    = $clog2(NB_BYTES);
    localparam logic [CNT_W-1:0]       LAST_BYTE = CNT_W'(NB_BYTES - 1);
    localparam logic [N_BITS_DATA-1:0] CMD_LOAD  = N_BITS_DATA'(8'h4C);
    localparam logic [N_BITS_DATA-1:0] CMD_RUN   = N_BITS_DATA'(8'h43);
    localparam logic [N_BITS_DATA-1:0] CMD_STEP  = N_BITS_DATA'(8'h53);
    localparam logic [N_BITS_DATA-1:0] CMD_NEXT  = N_BITS_DATA'(8'h4E);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_RUN,
        ST_STEP_WAIT,
        ST_STEP_EXEC,
        ST_TX_START,
        ST_TX_WAIT
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [NB_DATA-1:0]     r_word;
    logic [CNT_W-1:0]       r_byte_cnt;
    logic [ADDRWIDTH-1:0]   r_addr;
    logic [ADDRWIDTH-1:0]   r_pc;
    logic                   r_halt_seen;
    logic                   r_from_step;
    logic [CNT_W-1:0]       r_tx_idx;
    logic                   r_done;

    logic                   w_cmd_load;
    logic                   w_byte_take;
    logic                   w_write;
    logic                   w_capture;
    logic                   w_capture_step;
    logic                   w_tx_adv;
    logic                   w_report_done;
    logic [ADDRWIDTH-1:0]   w_addr_next;
    logic [NB_DATA-1:0]     w_pc_ext;
    logic [NB_DATA-1:0]     w_tx_shift;

    assign w_addr_next = r_addr + ADDRWIDTH'(4);
    assign w_pc_ext    = NB_DATA'(r_pc);
    assign w_tx_shift  = w_pc_ext << (N_BITS_DATA * int'(r_tx_idx));

    // State register; the whole controller freezes while the clock is unlocked
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else if (locked_i) begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus one-cycle strobes that drive the datapath
    always_comb begin
        w_next         = r_state;
        w_cmd_load     = 1'b0;
        w_byte_take    = 1'b0;
        w_write        = 1'b0;
        w_capture      = 1'b0;
        w_capture_step = 1'b0;
        w_tx_adv       = 1'b0;
        w_report_done  = 1'b0;
        case (r_state)
            ST_IDLE, ST_STEP_WAIT: begin
                if (rx_done_i) begin
                    case (rx_data_i)
                        CMD_LOAD: begin
                            w_next     = ST_LOAD;
                            w_cmd_load = 1'b1;
                        end
                        CMD_RUN: begin
                            // a halt already present at entry is honoured at once
                            if (halt_i) begin
                                w_next    = ST_TX_START;
                                w_capture = 1'b1;
                            end else begin
                                w_next = ST_RUN;
                            end
                        end
                        CMD_STEP: w_next = ST_STEP_WAIT;
                        CMD_NEXT: begin
                            if (r_state == ST_STEP_WAIT) begin
                                w_next = ST_STEP_EXEC;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (rx_done_i) begin
                    w_byte_take = 1'b1;
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                w_write = 1'b1;
                // stop on the halt word or when the address space is full
                if ((r_word == HALT_INSTR) || (w_addr_next == '0)) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (halt_i) begin
                    w_next    = ST_TX_START;
                    w_capture = 1'b1;
                end
            end
            ST_STEP_EXEC: begin
                w_next         = ST_TX_START;
                w_capture      = 1'b1;
                w_capture_step = 1'b1;
            end
            ST_TX_START: w_next = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (tx_done_i) begin
                    if (r_tx_idx == LAST_BYTE) begin
                        if (r_from_step && !r_halt_seen) begin
                            w_next = ST_STEP_WAIT;
                        end else begin
                            w_next        = ST_IDLE;
                            w_report_done = 1'b1;
                        end
                    end else begin
                        w_next   = ST_TX_START;
                        w_tx_adv = 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: word assembly, write address, captured PC and report progress
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_word      <= '0;
            r_byte_cnt  <= '0;
            r_addr      <= '0;
            r_pc        <= '0;
            r_halt_seen <= 1'b0;
            r_from_step <= 1'b0;
            r_tx_idx    <= '0;
            r_done      <= 1'b0;
        end else if (locked_i) begin
            if (w_cmd_load) begin
                r_addr     <= '0;
                r_byte_cnt <= '0;
                r_done     <= 1'b0;
            end
            if (w_byte_take) begin
                // MSB-first arrival: shifting left lands byte k in its slot
                r_word     <= {r_word[NB_DATA-N_BITS_DATA-1:0], rx_data_i};
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
            if (w_write) begin
                r_addr     <= w_addr_next;
                r_byte_cnt <= '0;
            end
            if (w_capture) begin
                r_pc        <= pc_i;
                r_halt_seen <= halt_i;
                r_from_step <= w_capture_step;
                r_tx_idx    <= '0;
            end
            if (w_tx_adv) begin
                r_tx_idx <= r_tx_idx + CNT_W'(1);
            end
            if (w_report_done) begin
                r_done <= 1'b1;
            end
        end
    end

    // Strobes are gated by locked_i so nothing fires while the clock settles
    always_comb begin
        enable_o     = locked_i && ((r_state == ST_RUN) || (r_state == ST_STEP_EXEC));
        en_write_o   = locked_i && (r_state == ST_WRITE);
        tx_start_o   = locked_i && (r_state == ST_TX_START);
        en_read_o    = (r_state == ST_RUN) || (r_state == ST_STEP_WAIT) ||
                       (r_state == ST_STEP_EXEC);
        debug_unit_o = (r_state == ST_IDLE) || (r_state == ST_LOAD) ||
                       (r_state == ST_WRITE);
    end

    assign wr_addr_o     = r_addr;
    assign instruction_o = r_word;
    assign tx_data_o     = w_tx_shift[NB_DATA-1 -: N_BITS_DATA];
    assign done_o        = r_done;

endmodule

// File: tb/tb_if_debug_ctrl.sv
// Scoreboard bench for if_debug_ctrl: expected writes and tx bytes are queued
// by the stimulus; a monitor pops and compares whenever the DUT strobes.
module tb_if_debug_ctrl;

    localparam int          AW   = 6;
    localparam logic [31:0] HALT = 32'hFC000000;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          locked_i;
    logic [7:0]    rx_data_i;
    logic          rx_done_i;
    logic          tx_done_i;
    logic          halt_i;
    logic [AW-1:0] pc_i;
    logic          en_write_o;
    logic [AW-1:0] wr_addr_o;
    logic [31:0]   instruction_o;
    logic          debug_unit_o;
    logic          en_read_o;
    logic          enable_o;
    logic          tx_start_o;
    logic [7:0]    tx_data_o;
    logic          done_o;

    if_debug_ctrl #(
        .NB_DATA(32), .N_BITS_DATA(8), .HALT_INSTR(HALT), .ADDRWIDTH(AW)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .locked_i(locked_i),
        .rx_data_i(rx_data_i), .rx_done_i(rx_done_i), .tx_done_i(tx_done_i),
        .halt_i(halt_i), .pc_i(pc_i), .en_write_o(en_write_o),
        .wr_addr_o(wr_addr_o), .instruction_o(instruction_o),
        .debug_unit_o(debug_unit_o), .en_read_o(en_read_o), .enable_o(enable_o),
        .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .done_o(done_o)
    );

    always #5 clock_i = ~clock_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [7:0]  txq[$];
    logic [31:0] prog[$];
    int          tx_cd = 0;
    int          en_cnt = 0;
    int          last_count = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_true(input string name, input bit cond);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s condition false, required true", name);
        end
    endtask

    // Monitor: pops the scoreboard on each write strobe and each tx start
    initial begin
        forever begin
            @(negedge clock_i);
            if (!reset_i) begin
                if (enable_o) en_cnt++;
                if (en_write_o) begin
                    chk_true("write_expected", wq_addr.size() != 0);
                    if (wq_addr.size() != 0) begin
                        chk("write_addr", 32'(wr_addr_o), wq_addr.pop_front());
                        chk("write_data", instruction_o, wq_data.pop_front());
                    end
                end
                if (tx_start_o) begin
                    chk_true("tx_expected", txq.size() != 0);
                    if (txq.size() != 0) chk("tx_byte", 32'(tx_data_o), 32'(txq.pop_front()));
                end
            end
        end
    end

    // UART transmitter stand-in: tx_done a few cycles after each start
    initial begin
        tx_done_i = 1'b0;
        forever begin
            @(negedge clock_i);
            tx_done_i = 1'b0;
            if (reset_i) begin
                tx_cd = 0;
            end else if (tx_cd > 0) begin
                tx_cd--;
                if (tx_cd == 0) tx_done_i = 1'b1;
            end else if (tx_start_o) begin
                tx_cd = $urandom_range(1, 4);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock_i);
        rx_data_i = b;
        rx_done_i = 1'b1;
        @(negedge clock_i);
        rx_done_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clock_i);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((wq_addr.size() != 0 || txq.size() != 0 || tx_cd != 0 || tx_done_i) && n < 3000) begin
            @(negedge clock_i);
            n++;
        end
        chk_true("quiet_timeout", n < 3000);
        repeat (4) @(negedge clock_i);
        @(posedge clock_i);
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        reset_i = 1'b1;
        wq_addr.delete();
        wq_data.delete();
        txq.delete();
        rx_done_i = 1'b0;
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    task automatic push_pc(input logic [AW-1:0] pc);
        logic [31:0] v;
        v = 32'(pc);
        for (int b = 0; b < 4; b++) txq.push_back(v[31-8*b -: 8]);
    endtask

    // Reference: word i goes to byte address 4*i modulo the address space;
    // loading stops after the halt word or after the last address is filled.
    task automatic do_load();
        logic [31:0] w;
        int words = 1 << (AW - 2);
        last_count = 0;
        send_byte(8'h4C);
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            wq_addr.push_back(32'((i * 4) % (1 << AW)));
            wq_data.push_back(w);
            for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8]);
            last_count++;
            if (w == HALT || last_count == words) break;
        end
        wait_quiet();
    endtask

    task automatic run_test(input logic [AW-1:0] pc, input int target);
        int cnt = 0;
        int n = 0;
        @(negedge clock_i);
        rx_data_i = 8'h43;
        rx_done_i = 1'b1;
        @(posedge clock_i);
        #1;
        rx_done_i = 1'b0;
        while (n < 2000) begin
            if (enable_o) cnt++;
            if (cnt == target && !halt_i) begin
                halt_i = 1'b1;
                pc_i   = pc;
                push_pc(pc);
            end
            if (halt_i && !enable_o && txq.size() == 0 && tx_cd == 0 && !tx_done_i) break;
            @(posedge clock_i);
            #1;
            n++;
        end
        chk_true("run_timeout", n < 2000);
        wait_quiet();
        halt_i = 1'b0;
        chk("run_enable_cycles", 32'(cnt), 32'(target));
        chk("run_done", 32'(done_o), 32'd1);
        chk("run_back_idle", 32'(debug_unit_o), 32'd1);
    endtask

    initial begin
        int base;
        int seen;
        logic [AW-1:0] pc;
        reset_i = 1'b1; locked_i = 1'b1; rx_data_i = '0; rx_done_i = 1'b0;
        halt_i = 1'b0; pc_i = '0;
        repeat (3) @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        chk("rst_debug_unit", 32'(debug_unit_o), 32'd1);
        chk("rst_enable", 32'(enable_o), 32'd0);
        chk("rst_en_write", 32'(en_write_o), 32'd0);
        chk("rst_en_read", 32'(en_read_o), 32'd0);
        chk("rst_tx_start", 32'(tx_start_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_instr", instruction_o, 32'd0);

        // Directed two-word program ending in the halt word
        prog = '{32'h20080005, HALT};
        do_load();
        chk("load_idle_debug", 32'(debug_unit_o), 32'd1);
        chk("load_idle_noread", 32'(en_read_o), 32'd0);
        chk("load_next_addr", 32'(wr_addr_o), 32'd8);

        // Partial word discarded by reset
        send_byte(8'h4C);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        do_reset();
        send_byte(8'h4C);
        wq_addr.push_back(32'd0);
        wq_data.push_back(32'h11223344);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_quiet();
        do_reset();
        chk("partial_reset_idle", 32'(debug_unit_o), 32'd1);

        // Random programs; the first one is long enough to wrap the address
        for (int it = 0; it < 4; it++) begin
            int n;
            n = (it == 0) ? 18 : $urandom_range(1, 20);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            prog.push_back(HALT);
            do_load();
            chk("rand_load_idle", 32'(debug_unit_o), 32'd1);
            chk("rand_load_next_addr", 32'(wr_addr_o), 32'((last_count * 4) % (1 << AW)));
        end

        // Unrecognised byte in IDLE is ignored
        send_byte(8'h55);
        wait_quiet();
        chk("junk_still_idle", 32'(debug_unit_o), 32'd1);
        chk("junk_no_read", 32'(en_read_o), 32'd0);

        // Continuous run, halted after a known number of enable cycles
        chk("done_low_before_run", 32'(done_o), 32'd0);
        run_test(6'h28, 10);
        run_test(AW'($urandom_range(0, 63)), $urandom_range(1, 30));

        // Halt already high when 'C' arrives: report without any enable
        pc = AW'($urandom_range(0, 63));
        halt_i = 1'b1; pc_i = pc;
        push_pc(pc);
        base = en_cnt;
        send_byte(8'h43);
        wait_quiet();
        halt_i = 1'b0;
        chk("halt_at_entry_no_enable", 32'(en_cnt - base), 32'd0);

        // 'L' clears done; a lone halt word is enough
        prog = '{HALT};
        do_load();
        chk("load_clears_done", 32'(done_o), 32'd0);

        // Single stepping without halt
        send_byte(8'h53);
        wait_quiet();
        chk("step_wait_read", 32'(en_read_o), 32'd1);
        chk("step_wait_noenable", 32'(enable_o), 32'd0);
        for (int s = 0; s < 6; s++) begin
            pc = (s < 3) ? AW'(4 * (s + 1)) : AW'($urandom_range(0, 63));
            pc_i = pc; halt_i = 1'b0;
            push_pc(pc);
            base = en_cnt;
            send_byte(8'h4E);
            wait_quiet();
            chk("step_one_enable", 32'(en_cnt - base), 32'd1);
            chk("step_stays_wait", 32'(en_read_o), 32'd1);
            chk("step_not_done", 32'(done_o), 32'd0);
        end

        // Step that hits a halt ends the session; later 'N' ignored
        pc = AW'($urandom_range(0, 63));
        pc_i = pc; halt_i = 1'b1;
        push_pc(pc);
        send_byte(8'h4E);
        wait_quiet();
        halt_i = 1'b0;
        chk("step_halt_done", 32'(done_o), 32'd1);
        chk("step_halt_idle", 32'(debug_unit_o), 32'd1);
        base = en_cnt;
        send_byte(8'h4E);
        wait_quiet();
        chk("n_in_idle_ignored", 32'(en_cnt - base), 32'd0);

        // Clock unlock mid-run freezes everything, then run resumes
        send_byte(8'h43);
        repeat (3) @(negedge clock_i);
        locked_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock_i);
            #1;
            if (enable_o || tx_start_o || en_write_o) seen++;
        end
        @(negedge clock_i);
        locked_i = 1'b1;
        chk("unlock_strobes_low", 32'(seen), 32'd0);
        @(posedge clock_i);
        #1;
        chk("run_resumes", 32'(enable_o), 32'd1);
        chk("run_resumes_read", 32'(en_read_o), 32'd1);
        pc = AW'($urandom_range(0, 63));
        halt_i = 1'b1; pc_i = pc;
        push_pc(pc);
        wait_quiet();
        halt_i = 1'b0;
        chk("lock_run_done", 32'(done_o), 32'd1);
        chk("lock_run_idle", 32'(debug_unit_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_debug_ctrl.md
# if_debug_ctrl

Sequencing controller for the instruction-fetch stage during bring-up and debug. It assembles instructions from the debug UART byte stream and writes them into instruction memory through the IF stage's write port. It then runs the processor either continuously or one cycle per command, and reports the halted or stepped PC back over the UART transmitter. It sits between the UART rx/tx modules and the IF stage, and is clocked by the gated processor clock.

## Interface

- NB_DATA, 32, instruction width
- N_BITS_DATA, 8, UART byte width
- HALT_INSTR, 32'hFC000000, encoding that terminates a load
- ADDRWIDTH, `ADDRWIDTH from parameters.vh, instruction-memory byte address width

Ports:

- clock_i  in  1  processor clock (gated, post-locked)
- reset_i  in  1  asynchronous, active-high reset
- locked_i  in  1  clock-wizard locked; FSM frozen while low
- rx_data_i  in  N_BITS_DATA  received byte
- rx_done_i  in  1  one-cycle pulse, rx_data_i valid
- tx_done_i  in  1  one-cycle pulse, previous byte fully sent
- halt_i  in  1  halt from IF stage
- pc_i  in  ADDRWIDTH  current PC from IF stage
- en_write_o  out  1  one-cycle instruction-memory write strobe
- wr_addr_o  out  ADDRWIDTH  write byte address
- instruction_o  out  NB_DATA  write data
- debug_unit_o  out  1  high while the debug unit owns instruction memory (IDLE/LOAD)
- en_read_o  out  1  instruction-memory read enable (high in RUN/STEP states)
- enable_o  out  1  PC/pipeline advance enable
- tx_start_o  out  1  one-cycle pulse, start sending tx_data_o
- tx_data_o  out  N_BITS_DATA  byte to transmit, stable until tx_done_i
- done_o  out  1  set on halt report complete; cleared on next 'L'

## Operation

- Reset value: all outputs 0 except debug_unit_o=1. State=IDLE. Address counter=0. Byte count=0.
- Commands are bytes received in IDLE or STEP_WAIT. Unrecognised bytes are ignored.
  - 'L' 0x4C → LOAD
  - 'C' 0x43 → RUN
  - 'S' 0x53 → STEP_WAIT
  - 'N' 0x4E → step (STEP_WAIT only)
- LOAD: bytes arrive MSB first; byte k fills bits [31-8k -: 8]. On the 4th byte, go to WRITE.
  - WRITE: en_write_o=1 for exactly one cycle, with wr_addr_o=counter and instruction_o=word.
  - Counter then increments by 4, modulo 2^ADDRWIDTH.
  - If word==HALT_INSTR, or the counter wraps to 0, go to IDLE. Otherwise return to LOAD.
  - 'L' resets the counter and byte count to 0 and clears done_o.
- RUN: enable_o=1, en_read_o=1, debug_unit_o=0.
  - When halt_i=1 in RUN, drop enable_o on the next edge, capture pc_i, and go to SEND.
- STEP_WAIT: enable_o=0, en_read_o=1.
  - On 'N', go to STEP_EXEC: enable_o=1 for exactly one cycle.
  - Then capture pc_i and halt_i into halt_seen, and go to SEND.
- SEND: transmit the captured PC zero-extended to 32 bits, MSB byte first, as 4 bytes.
  - Each byte is one tx_start_o pulse, then wait for tx_done_i.
  - After the 4th tx_done_i, the next state depends on the originating state:
    - from RUN: go to IDLE, done_o=1
    - from a step with halt_seen=1: go to IDLE, done_o=1
    - from a step with halt_seen=0: go to STEP_WAIT
- rx_done_i is ignored in RUN, STEP_EXEC, SEND and WRITE. Bytes are not queued.
- locked_i=0:
  - enable_o, en_write_o and tx_start_o are forced to 0.
  - State, counters and data registers hold.
  - Operation resumes where it stopped when locked_i returns to 1.
- Asynchronous reset mid-operation: immediate return to reset values. A partial word is discarded and a transfer in flight is abandoned.

## Timing

- Byte capture happens on the edge where rx_done_i=1.
- en_write_o is high in the cycle after the 4th byte's edge.
- The next byte is accepted from the cycle after the write.
- RUN: enable_o is high from the cycle after the 'C' edge. It goes low on the edge after halt_i is first seen high.
- STEP_EXEC: exactly one enable_o cycle per 'N'.
- SEND: the first tx_start_o comes one cycle after PC capture. Each subsequent tx_start_o comes one cycle after the preceding tx_done_i.
- halt_i arriving on the same edge as entry to RUN is honoured on that edge: enable_o stays 0.

## Test plan

- Load bytes 20 08 00 05, then FC 00 00 00, after 'L' → two en_write_o pulses:
  - addr 0 with data 0x20080005
  - addr 4 with data 0xFC000000
  - Then state IDLE and debug_unit_o=1.
- Load 3 bytes, then assert reset_i, then 'L' and 4 bytes 11 22 33 44 → single write of 0x11223344 at addr 0. The partial word is not written.
- 'C' with halt_i raised after 10 cycles and pc_i=0x28 → enable_o high for exactly 10 cycles. tx sends 00 00 00 28, then done_o=1.
- 'S', then 'N' three times with halt_i=0, pc_i=4/8/12 → three single-cycle enable_o pulses and three 4-byte reports. The FSM stays in STEP_WAIT.
- A step where halt_i=1 in STEP_EXEC → PC reported, done_o=1, state IDLE. A following 'N' is ignored.
- Drop locked_i for 5 cycles mid-RUN → enable_o=0 during the drop. No halt is reported, and RUN resumes afterwards.
